// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder. An accepted start loads both operands and the carry-in
// into internal registers. The block then does one full-adder step per clock,
// LSB first, and publishes result/cout after the last step. One operation
// takes WIDTH RUN cycles plus one DONE cycle.
//
// Optional feature: define SERIAL_SUB_EN to build in subtraction. With it,
// sub=1 at acceptance computes op_a - op_b as op_a + ~op_b + 1. Without it,
// sub is ignored.
//
// Handshake: start is sampled on every rising edge, but it is acted on only
// in IDLE. The operands are captured on the same edge that accepts start.
// While busy=1, start and the operand inputs are ignored. done is a single-
// cycle pulse, and result/cout are valid when done is high. They hold that
// value until the final step of the next operation.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a new operation (accepted in IDLE only)
//   op_a     in   operand A [WIDTH]
//   op_b     in   operand B [WIDTH]
//   cin_in   in   carry-in
//   sub      in   subtract request (only meaningful with SERIAL_SUB_EN)
//   busy     out  1 in RUN and DONE
//   done     out  one-cycle completion pulse
//   result   out  sum of the last completed operation [WIDTH]
//   cout     out  carry-out of the last completed operation
//   o_state  out  FSM state for debug (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [1:0]       o_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_s;
    logic             w_c_next;
    logic [WIDTH-1:0] w_sum_next;

    // Operand B and the carry as they are loaded on acceptance.
`ifdef SERIAL_SUB_EN
    always_comb begin
        w_b_load = op_b;
        w_c_load = cin_in;
        if (sub) begin
            // Two's-complement subtract: A + ~B + 1. cin_in is ignored.
            w_b_load = ~op_b;
            w_c_load = 1'b1;
        end
    end
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;

    always_comb begin
        w_b_load = op_b;
        w_c_load = cin_in;
    end
`endif

    // Full-adder step on the current LSBs.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next   = (r_a[0] & r_b[0]) | (r_b[0] & r_c) | (r_c & r_a[0]);

    // The sum bit enters at the MSB. After WIDTH steps, bit i sits at index i.
    assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= w_b_load;
                        r_c     <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c_next;
                    r_sum <= w_sum_next;
                    if (r_cnt == LAST_STEP) begin
                        // The last step publishes the result. The counter stays
                        // put instead of wrapping.
                        r_result <= w_sum_next;
                        r_cout   <= w_c_next;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign result  = r_result;
    assign cout    = r_cout;
    assign o_state = r_state;

endmodule
